// File: rtl/fpu_div_iter.sv
// fpu_div_iter
// Iterative IEEE-754 divider for the divide slot of the floating-point ALU.
// The quotient mantissa is produced by a radix-2 restoring loop, one bit per
// clock. Subnormal operands are flushed to signed zero and rounding is
// truncation (round-toward-zero).
//
// Ports
//   CLK, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous abort, beats every other transition
//   in_valid / in_ready   operand handshake; Rs1 = dividend, Rs2 = divisor
//   out_valid / out_ready result handshake; Result and flags are held in DONE
//   overflow, underflow, div_by_zero, invalid
//                         exception flags, meaningful only while out_valid=1
//   dbg_state             current FSM state (IDLE=0, CALC=1, NORM=2, DONE=3)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; the producer holds valid and its data until that edge, and
// ready never depends combinationally on valid.
module fpu_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int FLEN  = EXP_W + MAN_W + 1
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FLEN-1:0] Rs1,
    input  logic [FLEN-1:0] Rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] Result,
    output logic            overflow,
    output logic            underflow,
    output logic            div_by_zero,
    output logic            invalid,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = $clog2(MAN_W + 2);
    localparam int SE_W  = EXP_W + 2;          // signed working exponent width
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MAN_W + 1);
    localparam logic [SE_W-1:0]  EXP_MAX   = SE_W'((1 << EXP_W) - 1);
    localparam logic [SE_W-1:0]  BIAS_SE   = SE_W'(BIAS);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [FLEN-1:0]  QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    state_t state;

    // Operand unpack
    logic             s1, s2;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] f1, f2;

    assign {s1, e1, f1} = Rs1;
    assign {s2, e2, f2} = Rs2;

    // Classification; an all-zero exponent (zero or subnormal) counts as zero.
    logic zero1, zero2, inf1, inf2, nan1, nan2;

    assign zero1 = (e1 == '0);
    assign zero2 = (e2 == '0);
    assign inf1  = (e1 == EXP_ONES) && (f1 == '0);
    assign inf2  = (e2 == EXP_ONES) && (f2 == '0);
    assign nan1  = (e1 == EXP_ONES) && (f1 != '0);
    assign nan2  = (e2 == EXP_ONES) && (f2 != '0);

    // Special-case resolution, in priority order.
    logic            res_sign;
    logic            spec_hit;
    logic [FLEN-1:0] spec_res;
    logic            spec_inv;
    logic            spec_dbz;

    assign res_sign = s1 ^ s2;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (zero2 && !inf1) begin
            // finite non-zero dividend (0/0 already handled above)
            spec_res = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
            spec_dbz = 1'b1;
        end else if (inf1) begin
            spec_res = {res_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (zero1 || inf2) begin
            spec_res = {res_sign, {(FLEN-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // Biased exponent of the quotient before normalisation.
    logic [SE_W-1:0] exp_diff;

    assign exp_diff = SE_W'(e1) - SE_W'(e2) + BIAS_SE;

    // Divider datapath
    logic             sign_q;
    logic [SE_W-1:0]  exp_q;
    logic [MAN_W+1:0] rem_q;
    logic [MAN_W:0]   dvs_q;
    logic [MAN_W+1:0] quo_q;
    logic [CNT_W-1:0] cnt_q;

    // One extra bit on the trial subtraction gives the borrow / sign.
    logic [MAN_W+2:0] trial;
    logic             q_bit;
    logic [MAN_W+1:0] rem_keep;

    assign trial    = {1'b0, rem_q} - {2'b00, dvs_q};
    assign q_bit    = ~trial[MAN_W+2];
    assign rem_keep = q_bit ? trial[MAN_W+1:0] : rem_q;

    // Normalisation. The mantissa ratio lies in (0.5, 2), so either the
    // integer quotient bit or the one just below it is set.
    logic [MAN_W-1:0] norm_frac;
    logic [SE_W-1:0]  norm_exp;
    logic             norm_ovf;
    logic             norm_unf;

    always_comb begin
        norm_frac = '0;
        norm_exp  = exp_q;
        if (quo_q[MAN_W+1]) begin
            norm_frac = quo_q[MAN_W:1];
        end else begin
            norm_frac = quo_q[MAN_W-1:0];
            norm_exp  = exp_q - SE_W'(1);
        end
    end

    // norm_exp is two's complement: MSB set means negative.
    assign norm_ovf = !norm_exp[SE_W-1] && (norm_exp >= EXP_MAX);
    assign norm_unf = norm_exp[SE_W-1] || (norm_exp == '0);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            Result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= spec_hit && spec_dbz;
                        invalid     <= spec_hit && spec_inv;
                        sign_q      <= res_sign;
                        if (spec_hit) begin
                            Result <= spec_res;
                            state  <= DONE;
                        end else begin
                            exp_q <= exp_diff;
                            rem_q <= {1'b0, 1'b1, f1};
                            dvs_q <= {1'b1, f2};
                            quo_q <= '0;
                            cnt_q <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    // remainder stays below the divisor, so the shift cannot lose a bit
                    rem_q <= {rem_keep[MAN_W:0], 1'b0};
                    quo_q <= {quo_q[MAN_W:0], q_bit};
                    if (cnt_q == LAST_ITER) begin
                        cnt_q <= '0;
                        state <= NORM;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                NORM: begin
                    if (norm_ovf) begin
                        Result   <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                    end else if (norm_unf) begin
                        Result    <= {sign_q, {(FLEN-1){1'b0}}};
                        underflow <= 1'b1;
                    end else begin
                        Result <= {sign_q, norm_exp[EXP_W-1:0], norm_frac};
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fpu_div_iter.sv
`timescale 1ns/1ps
module tb_fpu_div_iter;

    localparam int W     = 36;   // {Result, overflow, underflow, div_by_zero, invalid}
    localparam int LAT_N = 26;   // edges from the accepting edge to out_valid, normal path
    localparam int LAT_S = 0;    // special cases are DONE right after the accepting edge

    logic        CLK;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Rs1;
    logic [31:0] Rs2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;
    logic        invalid;
    logic [1:0]  dbg_state;

    fpu_div_iter dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Rs1         (Rs1),
        .Rs2         (Rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Result      (Result),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero),
        .invalid     (invalid),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int           n_vec   = 0;
    int           n_err   = 0;
    int           acc_cyc = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    logic         ov_prev = 1'b0;
    int           lat_v;
    logic [W-1:0] exp_v;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        #1;
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (lat_q.size() == 0) begin
                    fail_now("unexpected_out_valid");
                end else begin
                    lat_v = lat_q.pop_front();
                    check("latency", W'(cyc - acc_cyc), W'(lat_v));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    exp_v = exp_q.pop_front();
                    check("result", {Result, overflow, underflow, div_by_zero, invalid}, exp_v);
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] flg, input int lat);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (!in_ready) begin
            fail_now("send_in_ready_timeout");
        end else begin
            exp_q.push_back({res, flg});
            lat_q.push_back(lat);
            Rs1      = a;
            Rs2      = b;
            in_valid = 1'b1;
            acc_cyc  = cyc + 1;   // cycle count just after the accepting edge
            @(negedge CLK);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_out(input int budget);
        int k = 0;
        while (!out_valid && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (!out_valid) fail_now("out_valid_timeout");
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        if (exp_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_q.delete();
            lat_q.delete();
        end
        @(negedge CLK);
    endtask

    // ---------------- directed vectors (hand-computed) ----------------
    localparam int NV = 14;
    logic [31:0] va [NV] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h7F000000,
                             32'h00800000, 32'h7F800000, 32'h7F800000, 32'h3F800000,
                             32'h7FC00001, 32'h00000001, 32'h7F800000, 32'hC1200000,
                             32'h40490FDB, 32'h3F800000};
    logic [31:0] vb [NV] = '{32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000,
                             32'h41000000, 32'h7F800000, 32'hC0000000, 32'hFF800000,
                             32'h3F800000, 32'h3F800000, 32'h00000000, 32'h40A00000,
                             32'h3F800000, 32'h80000000};
    logic [31:0] vr [NV] = '{32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000, 32'h7F800000,
                             32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
                             32'h7FC00000, 32'h00000000, 32'h7F800000, 32'hC0000000,
                             32'h40490FDB, 32'hFF800000};
    // {overflow, underflow, div_by_zero, invalid}
    logic [3:0]  vf [NV] = '{4'b0000, 4'b0010, 4'b0001, 4'b1000,
                             4'b0100, 4'b0001, 4'b0000, 4'b0000,
                             4'b0001, 4'b0000, 4'b0000, 4'b0000,
                             4'b0000, 4'b0010};
    int          vl [NV] = '{LAT_N, LAT_S, LAT_S, LAT_N,
                             LAT_N, LAT_S, LAT_S, LAT_S,
                             LAT_S, LAT_S, LAT_S, LAT_N,
                             LAT_N, LAT_S};

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Rs1       = '0;
        Rs2       = '0;

        #2;
        check("reset_in_ready",  W'(in_ready),  W'(1));
        check("reset_out_valid", W'(out_valid), W'(0));
        check("reset_result",    {Result, overflow, underflow, div_by_zero, invalid}, '0);
        check("reset_state",     W'(dbg_state), W'(0));

        #20;
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        // 6.0 / 2.0 and the return of in_ready one cycle after the handshake
        send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_N);
        wait_out(40);
        @(negedge CLK);
        check("in_ready_after_hs", W'(in_ready),  W'(1));
        check("out_valid_dropped", W'(out_valid), W'(0));

        for (int i = 0; i < NV; i++) begin
            send(va[i], vb[i], vr[i], vf[i], vl[i]);
        end
        drain(400);

        // backpressure: result held, new operands ignored
        out_ready = 1'b0;
        send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_N);
        wait_out(40);
        for (int i = 0; i < 5; i++) begin
            check("bp_result",    {Result, overflow, underflow, div_by_zero, invalid},
                  {32'h40400000, 4'b0000});
            check("bp_in_ready",  W'(in_ready),  W'(0));
            check("bp_out_valid", W'(out_valid), W'(1));
            Rs1      = 32'h3F800000;
            Rs2      = 32'h3F800000;
            in_valid = 1'b1;
            @(negedge CLK);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_in_ready",  W'(in_ready),  W'(1));
        check("bp_release_out_valid", W'(out_valid), W'(0));
        drain(10);

        // flush in the middle of the iteration loop, with in_valid high in the flush cycle
        Rs1      = 32'h40C00000;
        Rs2      = 32'h40000000;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (10) @(negedge CLK);
        check("flush_pre_state", W'(dbg_state), W'(1));
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge CLK);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_state",     W'(dbg_state), W'(0));
        check("flush_in_ready",  W'(in_ready),  W'(1));
        check("flush_out_valid", W'(out_valid), W'(0));
        repeat (30) @(negedge CLK);
        check("flush_no_result", W'(out_valid), W'(0));

        // asynchronous reset in the middle of the iteration loop
        Rs1      = 32'h3F800000;
        Rs2      = 32'h40400000;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (8) @(negedge CLK);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  W'(in_ready),  W'(1));
        check("arst_out_valid", W'(out_valid), W'(0));
        check("arst_result",    {Result, overflow, underflow, div_by_zero, invalid}, '0);
        check("arst_state",     W'(dbg_state), W'(0));
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, LAT_N);
        drain(60);

        if (lat_q.size() != 0) fail_now("latency_queue_not_empty");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (t=%0t)", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
